// File: rtl/dbg_run_ctrl.sv
// Run/step/check controller gating the Risc32 core clock-enable.
// Commands arrive on a valid/ready port; every command ends with a one-cycle rsp_valid pulse.
module dbg_run_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ERR_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_arg,
  input  logic [XLEN-1:0]       cmd_expect,
  output logic                  core_en,
  input  logic [PC_W-1:0]       core_pc,
  output logic [REG_ADDR_W-1:0] dbg_reg_addr,
  input  logic [XLEN-1:0]       dbg_reg_data,
  output logic                  rsp_valid,
  output logic                  rsp_pass,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  bp_hit,
  output logic                  busy,
  output logic [ERR_W-1:0]      err_count,
  output logic [CNT_W-1:0]      step_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHK_RD,
    S_CHK_CMP,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_STEP     = 3'd1,
    OP_RUN_N    = 3'd2,
    OP_RUN_FREE = 3'd3,
    OP_HALT     = 3'd4,
    OP_CHECK    = 3'd5,
    OP_CLR_ERR  = 3'd6,
    OP_SET_BP   = 3'd7
  } op_t;

  state_t                state, state_nxt;
  op_t                   op;
  logic                  accept;
  logic                  halt_acc;
  logic                  bp_stop;
  logic                  run_en;
  logic                  last_cycle;
  logic                  leave_run;
  logic [CNT_W-1:0]      remaining;
  logic [CNT_W-1:0]      executed;
  logic [CNT_W-1:0]      executed_nxt;
  logic                  free_mode;
  logic                  first;
  logic [PC_W-1:0]       bp_addr;
  logic                  bp_en;
  logic [REG_ADDR_W-1:0] chk_idx;
  logic [XLEN-1:0]       chk_exp;

  assign op = op_t'(cmd_op);

  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RUN:   cmd_ready = (op == OP_HALT);
      default: cmd_ready = 1'b0;
    endcase
  end

  assign accept   = cmd_valid & cmd_ready;
  assign halt_acc = (state == S_RUN) & accept;

  // The breakpoint is ignored on the first RUN cycle so a resume at the bp PC makes progress.
  assign bp_stop      = (state == S_RUN) & bp_en & (core_pc == bp_addr) & ~first;
  assign run_en       = (state == S_RUN) & ~bp_stop & ~halt_acc;
  assign last_cycle   = run_en & ~free_mode & (remaining == CNT_W'(1));
  assign leave_run    = halt_acc | bp_stop | last_cycle;
  assign executed_nxt = executed + CNT_W'(run_en);

  assign core_en      = run_en;
  assign rsp_valid    = (state == S_RESP);
  assign busy         = (state != S_IDLE);
  assign dbg_reg_addr = (state == S_CHK_RD) ? chk_idx : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_STEP, OP_RUN_FREE: state_nxt = S_RUN;
            OP_RUN_N:             state_nxt = (cmd_arg == '0) ? S_RESP : S_RUN;
            OP_CHECK:             state_nxt = S_CHK_RD;
            default:              state_nxt = S_RESP;
          endcase
        end
      end
      S_RUN:     if (leave_run) state_nxt = S_RESP;
      S_CHK_RD:  state_nxt = S_CHK_CMP;
      S_CHK_CMP: state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining  <= '0;
      executed   <= '0;
      free_mode  <= 1'b0;
      first      <= 1'b0;
      bp_addr    <= '0;
      bp_en      <= 1'b0;
      chk_idx    <= '0;
      chk_exp    <= '0;
      rsp_pass   <= 1'b0;
      rsp_data   <= '0;
      bp_hit     <= 1'b0;
      err_count  <= '0;
      step_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_STEP, OP_RUN_N, OP_RUN_FREE: begin
                remaining <= (op == OP_STEP) ? CNT_W'(1) : cmd_arg;
                free_mode <= (op == OP_RUN_FREE);
                first     <= 1'b1;
                executed  <= '0;
                if (op == OP_RUN_N && cmd_arg == '0) begin
                  rsp_data <= '0;
                  rsp_pass <= 1'b1;
                end else begin
                  bp_hit <= 1'b0;
                end
              end
              OP_CHECK: begin
                chk_idx <= cmd_arg[REG_ADDR_W-1:0];
                chk_exp <= cmd_expect;
              end
              OP_CLR_ERR: begin
                err_count <= '0;
                rsp_pass  <= 1'b1;
                rsp_data  <= '0;
              end
              OP_SET_BP: begin
                bp_addr  <= cmd_expect[PC_W-1:0];
                bp_en    <= cmd_arg[0];
                rsp_pass <= 1'b1;
                rsp_data <= '0;
              end
              default: begin
                rsp_pass <= 1'b1;
                rsp_data <= '0;
              end
            endcase
          end
        end
        S_RUN: begin
          first <= 1'b0;
          if (run_en) begin
            executed   <= executed_nxt;
            step_count <= step_count + CNT_W'(1);
            if (!free_mode) remaining <= remaining - CNT_W'(1);
          end
          // A HALT arriving on the breakpoint cycle wins, so the stop is reported as a halt.
          if (leave_run) begin
            rsp_data <= XLEN'(executed_nxt);
            rsp_pass <= 1'b1;
            bp_hit   <= bp_stop & ~halt_acc;
          end
        end
        S_CHK_CMP: begin
          rsp_data <= dbg_reg_data;
          rsp_pass <= (dbg_reg_data == chk_exp);
          if (dbg_reg_data != chk_exp && err_count != '1)
            err_count <= err_count + ERR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: directed and random commands checked against an arithmetic model
// of run length, breakpoint stop, register compare and counters.
module tb_dbg_run_ctrl;
  localparam int unsigned XLEN = 32, PC_W = 32, RAW = 3, CNT_W = 16, ERR_W = 4;
  localparam logic [2:0] NOP = 3'd0, STEP = 3'd1, RUN_N = 3'd2, RUN_FREE = 3'd3,
                         HALT = 3'd4, CHECK = 3'd5, CLR_ERR = 3'd6, SET_BP = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic [XLEN-1:0]  cmd_expect;
  logic             core_en;
  logic [PC_W-1:0]  pc = '0;
  logic [RAW-1:0]   dbg_reg_addr;
  logic [XLEN-1:0]  dbg_reg_data;
  logic             rsp_valid, rsp_pass, bp_hit, busy;
  logic [XLEN-1:0]  rsp_data;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] step_count;

  dbg_run_ctrl #(.XLEN(XLEN), .PC_W(PC_W), .REG_ADDR_W(RAW), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .cmd_expect(cmd_expect), .core_en(core_en), .core_pc(pc),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data), .rsp_valid(rsp_valid),
    .rsp_pass(rsp_pass), .rsp_data(rsp_data), .bp_hit(bp_hit), .busy(busy),
    .err_count(err_count), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Core and register-file stand-ins: PC advances by 4 per enabled cycle, reads have one-cycle latency.
  logic        pc_load = 1'b0;
  logic [31:0] pc_init = '0;
  logic [31:0] rf [8];
  int          en_cnt = 0;

  always @(posedge clk) begin
    if (pc_load)      pc <= pc_init;
    else if (core_en) pc <= pc + 32'd4;
    if (core_en) en_cnt <= en_cnt + 1;
    dbg_reg_data <= rf[dbg_reg_addr];
  end

  int n_chk = 0, n_fail = 0;
  int unsigned m_step, m_err;
  logic        m_bp_en, m_bp_hit;
  logic [31:0] m_bp_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_err = 0; m_bp_en = 1'b0; m_bp_addr = '0; m_bp_hit = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_core_en", core_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_pass", rsp_pass, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_step_count", step_count, 0);
    check("rst_dbg_reg_addr", dbg_reg_addr, 0);
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk); pc_load = 1'b1; pc_init = v;
    @(negedge clk); pc_load = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 400);
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  // Issue one command from IDLE, predict its outcome and compare the response.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] arg, input logic [31:0] ex);
    int t, e0, lat, x_exec, x_lat;
    int unsigned n;
    longint unsigned j;
    logic [31:0] x_data, d;
    logic x_pass, has_data;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_expect = ex;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    check("cmd_ready_idle", cmd_ready, 1);
    x_exec = 0; x_lat = 1; x_data = '0; x_pass = 1'b1; has_data = 1'b0;
    case (op)
      STEP, RUN_N: begin
        n = (op == STEP) ? 1 : int'(arg);
        has_data = 1'b1;
        if (n != 0) begin
          d = m_bp_addr - pc;
          j = (m_bp_en && d != 0 && d[1:0] == 2'b00) ? longint'(d >> 2) : 64'hFFFF_FFFF;
          x_exec   = (n < j) ? int'(n) : int'(j);
          m_bp_hit = m_bp_en && (j < n);
          x_lat    = x_exec + 1 + (m_bp_hit ? 1 : 0);
          x_data   = 32'(x_exec);
          m_step   = (m_step + x_exec) % 65536;
        end
      end
      CHECK: begin
        has_data = 1'b1;
        x_data = rf[arg[2:0]];
        x_pass = (x_data == ex);
        if (!x_pass && m_err < 15) m_err++;
        x_lat = 3;
      end
      CLR_ERR: m_err = 0;
      SET_BP: begin m_bp_en = arg[0]; m_bp_addr = ex; end
      default: ;
    endcase
    e0 = en_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    wait_rsp(lat);
    check("rsp_latency", lat, x_lat);
    check("rsp_pass", rsp_pass, x_pass);
    if (has_data) check("rsp_data", rsp_data, x_data);
    check("bp_hit", bp_hit, m_bp_hit);
    check("err_count", err_count, m_err);
    check("step_count", step_count, m_step);
    check("core_en_cycles", en_cnt - e0, x_exec);
    @(negedge clk);
    check("rsp_valid_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    int t, e0, lat;
    logic [2:0] rop;
    logic [31:0] rex;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = '0; cmd_expect = '0;
    for (int i = 0; i < 8; i++) rf[i] = 32'h100 + 32'(i);
    rf[3] = 32'h0000_0001;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outs();
    @(negedge clk); rst_n = 1'b1;

    repeat (3) run_cmd(STEP, 16'd0, 32'd0);
    check("step_x3_count", step_count, 3);

    set_pc(32'h0);
    run_cmd(SET_BP, 16'd1, 32'h14);
    run_cmd(RUN_N, 16'd10, 32'd0);
    check("bp_stop_pc", pc, 32'h14);
    run_cmd(RUN_N, 16'd2, 32'd0);
    check("bp_resume_pc", pc, 32'h1C);

    run_cmd(CHECK, 16'd3, 32'd1);
    run_cmd(CHECK, 16'd3, 32'd2);
    run_cmd(CLR_ERR, 16'd0, 32'd0);

    // Free run halted after seven enabled cycles; a non-HALT offer mid-run must stall.
    run_cmd(SET_BP, 16'd0, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = RUN_FREE; cmd_arg = '0;
    check("free_ready", cmd_ready, 1);
    e0 = en_cnt;
    @(posedge clk); #1 cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk); t++;
      cmd_valid = 1'b0;
      if (en_cnt - e0 == 3) begin
        cmd_valid = 1'b1; cmd_op = CHECK;
        #1;
        check("run_nonhalt_ready", cmd_ready, 0);
        check("run_nonhalt_core_en", core_en, 1);
        check("run_busy", busy, 1);
      end
    end while (en_cnt - e0 < 7 && t < 100);
    cmd_valid = 1'b1; cmd_op = HALT;
    #1;
    check("halt_ready", cmd_ready, 1);
    check("halt_core_en", core_en, 0);
    @(posedge clk); #1 cmd_valid = 1'b0; cmd_op = NOP;
    wait_rsp(lat);
    m_step = (m_step + 7) % 65536;
    m_bp_hit = 1'b0;
    check("halt_rsp_data", rsp_data, 7);
    check("halt_en_cycles", en_cnt - e0, 7);
    check("halt_bp_hit", bp_hit, 0);
    check("halt_step_count", step_count, m_step);

    for (int i = 0; i < 17; i++) run_cmd(CHECK, 16'd3, 32'd2);
    check("err_saturated", err_count, 15);
    run_cmd(RUN_N, 16'd0, 32'd0);

    for (int i = 0; i < 8; i++) rf[i] = $urandom;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == RUN_FREE) rop = STEP;
      case (rop)
        RUN_N:  run_cmd(RUN_N, 16'($urandom_range(0, 12)), 32'd0);
        CHECK: begin
          t = $urandom_range(0, 7);
          rex = ($urandom_range(0, 1) == 1) ? rf[t] : $urandom;
          run_cmd(CHECK, 16'(t), rex);
        end
        SET_BP: begin
          rex = pc + 32'(4 * $urandom_range(1, 8)) + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
          run_cmd(SET_BP, 16'($urandom_range(0, 1)), rex);
        end
        default: run_cmd(rop, 16'($urandom), $urandom);
      endcase
    end

    // Asynchronous reset in the middle of a long run.
    run_cmd(CHECK, 16'd3, 32'd9);
    run_cmd(SET_BP, 16'd0, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = RUN_N; cmd_arg = 16'd100;
    e0 = en_cnt;
    @(posedge clk); #1 cmd_valid = 1'b0; cmd_op = NOP;
    t = 0;
    while (en_cnt - e0 < 20 && t < 100) begin @(negedge clk); t++; end
    check("pre_reset_core_en", core_en, 1);
    rst_n = 1'b0;
    #1 check_reset_outs();
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run_cmd(CHECK, 16'd5, rf[5]);
    run_cmd(CHECK, 16'd5, rf[5] ^ 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dbg_run_ctrl.md
Name: dbg_run_ctrl

Overview:
- Synthesizable run/step/check controller that gates the Risc32 core clock-enable. It replaces hand-written clock toggling and per-step register checks with a command interface.
- It supports single-step, run-N-cycles, free-run, PC breakpoint and register-compare-against-expected with a saturating error count.
- It sits between a host or bench command source and the core's enable, PC and debug register-read ports.

Parameters:
XLEN, 32, data/register width
PC_W, 32, program counter width
REG_ADDR_W, 3, register-file index width
CNT_W, 16, width of cycle argument and counters
ERR_W, 4, width of saturating error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  0 NOP, 1 STEP, 2 RUN_N, 3 RUN_FREE, 4 HALT, 5 CHECK, 6 CLR_ERR, 7 SET_BP
cmd_arg  in  CNT_W  cycle count (RUN_N); register index in [REG_ADDR_W-1:0] (CHECK); bit0 = bp enable (SET_BP)
cmd_expect  in  XLEN  expected value (CHECK); breakpoint address in [PC_W-1:0] (SET_BP)
core_en  out  1  core clock-enable; the core advances one instruction per clk with core_en=1
core_pc  in  PC_W  core current PC
dbg_reg_addr  out  REG_ADDR_W  register read index
dbg_reg_data  in  XLEN  register read data, valid one clk after dbg_reg_addr
rsp_valid  out  1  one-cycle completion pulse
rsp_pass  out  1  command result
rsp_data  out  XLEN  cycles executed (STEP/RUN_*, zero-extended) or register value read (CHECK)
bp_hit  out  1  last run stopped on the breakpoint
busy  out  1  state != IDLE
err_count  out  ERR_W  saturating CHECK-failure count
step_count  out  CNT_W  total enabled cycles since reset, wraps

Behaviour:
- Reset (async, rst_n low): state=IDLE, and every output is 0 (core_en, rsp_*, bp_hit, busy, err_count, step_count, dbg_reg_addr). Breakpoint address=0, bp enable=0. core_en drops immediately, even mid-run.
- States: IDLE, RUN, CHK_RD, CHK_CMP, RESP.
- cmd_ready:
  - 1 in IDLE.
  - In RUN, 1 only when cmd_op==HALT.
  - 0 in CHK_RD, CHK_CMP and RESP.
- IDLE accept:
  - STEP: load remaining=1, go to RUN.
  - RUN_N: load remaining=cmd_arg, go to RUN. cmd_arg==0 goes straight to RESP with rsp_data=0, rsp_pass=1, and no core_en.
  - RUN_FREE: set the free flag, go to RUN.
  - CHECK: latch index and expect, go to CHK_RD.
  - CLR_ERR: err_count=0.
  - SET_BP: latch address and enable.
  - NOP, HALT: no action.
  - All IDLE-only commands (CLR_ERR, SET_BP, NOP, HALT) go to RESP with rsp_pass=1.
- RUN:
  - core_en is combinational: (state==RUN) & ~bp_stop.
  - bp_stop = bp_en & (core_pc==bp_addr) & ~first. `first` is high only on the first RUN cycle, so resuming from a breakpoint PC executes that instruction.
  - Each core_en cycle: executed++ and step_count++. remaining-- unless in free mode.
  - Leave RUN for RESP on the cycle after the last enabled cycle (remaining reaches 0), or on the bp_stop cycle (bp_hit=1, no core_en that cycle), or on HALT accept.
  - HALT accept has priority over the enabled cycle in the same clk: core_en=0 that clk.
  - rsp_data=executed, rsp_pass=1.
  - bp_hit is cleared at each RUN entry.
- CHK_RD: dbg_reg_addr=index for one cycle, then CHK_CMP.
- CHK_CMP:
  - Sample dbg_reg_data into rsp_data.
  - rsp_pass = (dbg_reg_data==expect).
  - On mismatch, err_count++, saturating at 2^ERR_W-1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_* hold their values until the next RESP.
- Latency:
  - STEP: accept, one core_en cycle, rsp_valid 2 clk after accept.
  - CHECK: rsp_valid 3 clk after accept.
- Counters wrap/saturate as stated. No X propagation from dbg_reg_data outside CHK_CMP.

Test Plan:
- Reset, then STEP x3 -> core_en high exactly 1 clk per command, step_count=3, each rsp_data=1.
- SET_BP addr=0x14 en=1; RUN_N arg=10 with the PC model stepping +4 per enabled cycle from 0 -> core_en high 5 clk, stops at pc 0x14, bp_hit=1, rsp_data=5. A second RUN_N 2 -> executes 2 (pc 0x1C), bp_hit=0.
- Register model x3=0x00000001: CHECK idx3 expect 1 -> rsp_pass=1, err_count=0. CHECK idx3 expect 2 -> rsp_pass=0, rsp_data=1, err_count=1. CLR_ERR -> err_count=0.
- RUN_FREE, then HALT offered after 7 enabled cycles -> core_en low on the HALT clk, rsp_data=7. Non-HALT ops while in RUN see cmd_ready=0.
- RUN_N arg=100, rst_n low after 20 cycles -> core_en 0 immediately, all outputs 0; after release, CHECK is accepted normally.
- 17 failing CHECKs with ERR_W=4 -> err_count saturates at 15. RUN_N arg=0 -> rsp_valid with no core_en, rsp_data=0.
